// File: rtl/booth_mult_seq_if.sv
// Operand/product bus bundle for booth_mult_seq.
// The producer/consumer side uses master, the multiplier uses slave.
interface booth_mult_seq_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic             unsgn;
  logic [WIDTH-1:0] inBus;
  logic             ready;
  logic             outValid;
  logic             outHi;
  logic             done;
  logic [WIDTH-1:0] outBus;

  modport master (
    output start, unsgn, inBus,
    input  ready, outValid, outHi, done, outBus
  );

  modport slave (
    input  start, unsgn, inBus,
    output ready, outValid, outHi, done, outBus
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands.
// Operands in on one bus (two beats), product out high word then low.
module booth_mult_seq #(
  parameter int WIDTH = 6
) (
  input logic             clk,
  input logic             rst,
  booth_mult_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOADY,
    CALC,
    OUTH,
    OUTL
  } stateT;

  stateT          state;
  logic [WIDTH:0] x;
  logic [WIDTH:0] a;
  logic [WIDTH:0] y;
  logic           yM1;
  logic [CW-1:0]  cnt;
  logic           modeU;

  logic             readyR;
  logic             outValidR;
  logic             outHiR;
  logic             doneR;
  logic [WIDTH-1:0] outBusR;

  logic [WIDTH:0] xExt;
  logic [WIDTH:0] yExt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] aNx;
  logic [WIDTH:0] yNx;

  // X follows the mode seen on the bus; Y follows the latched mode.
  assign xExt = {~bus.unsgn & bus.inBus[WIDTH-1], bus.inBus};
  assign yExt = {~modeU & bus.inBus[WIDTH-1], bus.inBus};

  // One Booth step: add/sub per {Y0,Y-1}, then arithmetic shift.
  always_comb begin
    sum = a;
    unique case ({y[0], yM1})
      2'b10:   sum = a - x;
      2'b01:   sum = a + x;
      default: sum = a;
    endcase
    aNx = {sum[WIDTH], sum[WIDTH:1]};
    yNx = {sum[0], y[WIDTH:1]};
  end

  // Controller, datapath registers and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      a         <= '0;
      y         <= '0;
      yM1       <= 1'b0;
      cnt       <= '0;
      modeU     <= 1'b0;
      readyR    <= 1'b1;
      outValidR <= 1'b0;
      outHiR    <= 1'b0;
      doneR     <= 1'b0;
      outBusR   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            x      <= xExt;
            modeU  <= bus.unsgn;
            readyR <= 1'b0;
            state  <= LOADY;
          end
        end
        LOADY: begin
          y     <= yExt;
          a     <= '0;
          yM1   <= 1'b0;
          cnt   <= '0;
          state <= CALC;
        end
        CALC: begin
          a   <= aNx;
          y   <= yNx;
          yM1 <= y[0];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH)) begin
            outValidR <= 1'b1;
            outHiR    <= 1'b1;
            outBusR   <= {aNx[WIDTH-2:0], yNx[WIDTH]};
            state     <= OUTH;
          end
        end
        OUTH: begin
          outHiR  <= 1'b0;
          doneR   <= 1'b1;
          outBusR <= y[WIDTH-1:0];
          state   <= OUTL;
        end
        OUTL: begin
          outValidR <= 1'b0;
          doneR     <= 1'b0;
          outBusR   <= '0;
          readyR    <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready    = readyR;
  assign bus.outValid = outValidR;
  assign bus.outHi    = outHiR;
  assign bus.done     = doneR;
  assign bus.outBus   = outBusR;
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised, self-controlled sequential Booth (radix-2) multiplier with its own controller and an added signed/unsigned mode.
- Operands arrive one per cycle on a shared input bus: multiplicand first, then multiplier.
- The 2*WIDTH-bit product leaves on a shared output bus in two beats: high word first, then low word.
- It is a drop-in arithmetic unit for the bus-based datapaths, replacing the separate fixed-6-bit datapath/controller pair.

Parameters:
- WIDTH, 6, operand width in bits (must be ≥ 2); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- unsgn  input  1  operand mode; 1 = unsigned, 0 = two's-complement signed. Latched together with the multiplicand.
- inBus  input  WIDTH  operand bus: multiplicand in the start cycle, multiplier in the following cycle.
- ready  output  1  1 only in IDLE.
- outValid  output  1  outBus carries a product word this cycle.
- outHi  output  1  with outValid: 1 = high word, 0 = low word.
- done  output  1  one-cycle pulse, coincident with the low-word beat.
- outBus  output  WIDTH  product word; driven to 0 when outValid=0 (no tristate inside this block).

Behaviour:
- Reset (rst=1 at a clock edge, in any state, including mid-operation):
  - state → IDLE.
  - X, A, Y, Y-1 register and iteration counter all cleared to 0.
  - Outputs after reset: ready=1, outValid=0, outHi=0, done=0, outBus=0.
  - Reset has priority over start.
- Internal widths:
  - X, A and Y are WIDTH+1 bits.
  - Operands are sign-extended when unsgn=0 and zero-extended when unsgn=1.
  - The iteration count is always WIDTH+1, in both modes.
- States: IDLE, LOADY, CALC, OUTH, OUTL.
- IDLE:
  - If start=1 at an edge: X ← ext(inBus), mode ← unsgn, go to LOADY.
  - start=0: stay in IDLE.
- LOADY:
  - Unconditionally at the next edge: Y ← ext(inBus), A ← 0, Y-1 ← 0, count ← 0, go to CALC.
  - start and inBus are not checked for validity in this cycle; the producer must present the multiplier here.
- CALC (one iteration per cycle):
  - {Y0,Y-1}=10: A' = A − X.
  - {Y0,Y-1}=01: A' = A + X.
  - {Y0,Y-1}=00 or 11: A' = A.
  - Add/subtract is modulo 2^(WIDTH+1).
  - Then arithmetic right shift of {A',Y,Y-1}: the sign bit of A' is replicated, A'[0] enters Y's MSB, Y0 enters Y-1.
  - count increments each CALC cycle; after the (WIDTH+1)th iteration, go to OUTH.
- Product: P = {A,Y}[2*WIDTH-1:0]. Exact in both modes.
- OUTH: outValid=1, outHi=1, outBus = P[2*WIDTH-1:WIDTH]; go to OUTL.
- OUTL: outValid=1, outHi=0, done=1, outBus = P[WIDTH-1:0]; go to IDLE.
- Timing (cycle 0 = edge where start is accepted; outputs are registered-state decodes):
  - Cycle 1: LOADY.
  - Cycles 2..WIDTH+2: CALC.
  - Cycle WIDTH+3: OUTH.
  - Cycle WIDTH+4: OUTL.
  - Cycle WIDTH+5: IDLE, ready=1.
  - Throughput: one product per WIDTH+5 cycles.
  - start may be asserted during OUTL, but is not accepted until IDLE.
- start while ready=0: ignored, with no effect on the operation in flight.
- unsgn changes after the start cycle: no effect on the operation in flight.
- Boundary operands, all exact:
  - Most-negative signed × most-negative signed.
  - All-ones unsigned × all-ones unsigned.
  - Zero operands.

Test Plan:
- WIDTH=6, signed: X=5 (0x05), Y=−3 (0x3D) → OUTH outBus=0x3F, OUTL outBus=0x31 (−15). outValid at cycles 9 and 10; done only at cycle 10; ready returns at cycle 11.
- WIDTH=6, signed: −32×−32 (0x20, 0x20) → 0x10, 0x00 (1024). Also −32×31 (0x20, 0x1F) → 0x30, 0x20 (−992).
- WIDTH=6, unsigned: 63×63 (0x3F, 0x3F) → 0x3E, 0x01 (3969). The same bus values with unsgn=0 → 0x00, 0x01 (+1).
- Robustness:
  - Assert start continuously through one operation → exactly one operation per IDLE visit, and the result is unaffected.
  - Pulse rst during CALC → next cycle ready=1, outValid=0, outBus=0; a following operation (7×9) gives 0x00, 0x3F (63).
- Parameter sweep WIDTH=4, 8, 16:
  - Random signed and unsigned operands are checked against a reference model, including 0×x, x×0 and extreme values.
  - Latency is exactly WIDTH+3 cycles to the first beat.
